// File: rtl/rvv_xrf_wb_collector_if.sv
// Scalar-regfile writeback bundle: N_IN-lane retire input side, single-port
// writeback output side, plus the pending-write mask and fill level.
interface rvv_xrf_wb_collector_if #(
  parameter int N_IN   = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [N_IN-1:0]        in_valid;
  logic [N_IN*ADDR_W-1:0] in_addr;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_ready;
  logic                   async_rd_valid;
  logic [ADDR_W-1:0]      async_rd_addr;
  logic [DATA_W-1:0]      async_rd_data;
  logic                   async_rd_ready;
  logic [2**ADDR_W-1:0]   pending_mask;
  logic [CNT_W-1:0]       fill_level;

  modport master (
    output in_valid, in_addr, in_data, async_rd_ready,
    input  in_ready, async_rd_valid, async_rd_addr, async_rd_data,
           pending_mask, fill_level
  );

  modport slave (
    input  in_valid, in_addr, in_data, async_rd_ready,
    output in_ready, async_rd_valid, async_rd_addr, async_rd_data,
           pending_mask, fill_level
  );
endinterface

// File: rtl/rvv_xrf_wb_collector.sv
// Collects up to N_IN in-order vector retire writes per cycle into a circular
// FIFO and drains them one per cycle onto the scalar regfile writeback port.
module rvv_xrf_wb_collector #(
  parameter int N_IN   = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic                   clk,
  input logic                   rstn,
  rvv_xrf_wb_collector_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  ptr_t              rptr, wptr;
  cnt_t              count;

  logic [N_IN-1:0]   lane_acc, lane_wr;
  ptr_t              lane_idx [N_IN];
  cnt_t              n_push;
  logic              pop;

  // Modulo-DEPTH add; n never exceeds DEPTH so one correction suffices,
  // which keeps non-power-of-2 depths working.
  function automatic ptr_t ptr_add(input ptr_t p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return ptr_t'(s);
  endfunction

  // Space is judged from the registered count only; a same-cycle pop does
  // not free a slot until the next cycle.
  always_comb begin
    for (int i = 0; i < N_IN; i++) bus.in_ready[i] = (DEPTH - int'(count)) > i;
  end

  // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
  always_comb begin
    lane_acc = bus.in_valid & bus.in_ready;
    lane_wr  = '0;
    n_push   = '0;
    for (int i = 0; i < N_IN; i++) begin
      lane_idx[i] = ptr_add(wptr, 32'(n_push));
      // x0 writes are handshaken but dropped; survivors compact in lane order.
      lane_wr[i]  = lane_acc[i] && (bus.in_addr[i*ADDR_W +: ADDR_W] != '0);
      if (lane_wr[i]) n_push = cnt_t'(n_push + 1'b1);
    end
  end

  assign pop = (count != '0) && bus.async_rd_ready;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (pop) rptr <= ptr_add(rptr, 1);
      wptr  <= ptr_add(wptr, 32'(n_push));
      count <= count + n_push - cnt_t'(pop);
    end
  end

  // NOTE: storage is not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (lane_wr[i]) begin
        mem_addr[lane_idx[i]] <= bus.in_addr[i*ADDR_W +: ADDR_W];
        mem_data[lane_idx[i]] <= bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Head is presented straight from storage; zeroed when empty.
  assign bus.async_rd_valid = (count != '0);
  assign bus.async_rd_addr  = bus.async_rd_valid ? mem_addr[rptr] : '0;
  assign bus.async_rd_data  = bus.async_rd_valid ? mem_data[rptr] : '0;
  assign bus.fill_level     = count;

  always_comb begin
    bus.pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count)) bus.pending_mask[mem_addr[ptr_add(rptr, k)]] = 1'b1;
    end
    bus.pending_mask[0] = 1'b0;
  end

  // Retire lanes must be valid contiguously from lane 0.
  for (genvar g = 1; g < N_IN; g++) begin : g_contig
    a_contig: assert property (@(posedge clk) disable iff (!rstn)
      bus.in_valid[g] |-> bus.in_valid[g-1])
      else $error("in_valid gap at lane %0d", g);
  end
endmodule

// File: tb/tb_rvv_xrf_wb_collector.sv
// Directed table-driven bench for rvv_xrf_wb_collector plus hand-written
// reset, wrap and duplicate-address sequences checked against a queue model.
module tb_rvv_xrf_wb_collector;
  localparam int DEPTH = 4;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_err    = 0;

  rvv_xrf_wb_collector_if bus ();
  rvv_xrf_wb_collector dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        rdy;
    logic [1:0]  e_rdy;
    logic        e_vld;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_fill;
    logic [31:0] e_mask;
  } vec_t;

  vec_t        vt [16];
  logic [36:0] q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic rdy);
    bus.in_valid       = v;
    bus.in_addr        = {a1, a0};
    bus.in_data        = {d1, d0};
    bus.async_rd_ready = rdy;
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_rdy, input logic e_vld,
                           input logic [4:0] e_addr, input logic [31:0] e_data,
                           input logic [2:0] e_fill, input logic [31:0] e_mask);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'(e_rdy));
    check({tag, " valid"},    64'(bus.async_rd_valid), 64'(e_vld));
    check({tag, " addr"},     64'(bus.async_rd_addr), 64'(e_addr));
    check({tag, " data"},     64'(bus.async_rd_data), 64'(e_data));
    check({tag, " fill"},     64'(bus.fill_level), 64'(e_fill));
    check({tag, " mask"},     64'(bus.pending_mask), 64'(e_mask));
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i][36:32]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_model(input string tag);
    logic [1:0] er;
    for (int l = 0; l < 2; l++) er[l] = (DEPTH - q.size()) > l;
    if (q.size() != 0)
      check_all(tag, er, 1'b1, q[0][36:32], q[0][31:0], 3'(q.size()), model_mask());
    else
      check_all(tag, er, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0);
  endtask

  // Applies one cycle of stimulus to the model: pop first, then enqueue
  // accepted non-x0 lanes against the pre-edge occupancy.
  task automatic step_model(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1, input logic rdy);
    int  space;
    bit  do_pop;
    space  = DEPTH - q.size();
    do_pop = (q.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (v[0] && space > 0 && a0 != 0) q.push_back({a0, d0});
    if (v[1] && space > 1 && a1 != 0) q.push_back({a1, d1});
  endtask

  initial begin
    logic [1:0]  v;
    logic [4:0]  a [2];
    logic [31:0] d [2];
    logic        rdy;

    vt[0]  = '{2'b11, 5,  32'hAAAA0001, 6, 32'hBBBB0002, 1, 2'b11, 0, 0,  32'h0,        0, 32'h0};
    vt[1]  = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b11, 1, 5,  32'hAAAA0001, 2, 32'h60};
    vt[2]  = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b11, 1, 6,  32'hBBBB0002, 1, 32'h40};
    vt[3]  = '{2'b11, 1,  32'h11,       2, 32'h22,       0, 2'b11, 0, 0,  32'h0,        0, 32'h0};
    vt[4]  = '{2'b11, 3,  32'h33,       4, 32'h44,       0, 2'b11, 1, 1,  32'h11,       2, 32'h6};
    vt[5]  = '{2'b11, 8,  32'h88,       9, 32'h99,       0, 2'b00, 1, 1,  32'h11,       4, 32'h1E};
    vt[6]  = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b00, 1, 1,  32'h11,       4, 32'h1E};
    vt[7]  = '{2'b11, 10, 32'hA0,       11, 32'hB0,      0, 2'b01, 1, 2,  32'h22,       3, 32'h1C};
    vt[8]  = '{2'b01, 11, 32'hB0,       0, 32'h0,        1, 2'b00, 1, 2,  32'h22,       4, 32'h41C};
    vt[9]  = '{2'b01, 11, 32'hB0,       0, 32'h0,        1, 2'b01, 1, 3,  32'h33,       3, 32'h418};
    vt[10] = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b01, 1, 4,  32'h44,       3, 32'hC10};
    vt[11] = '{2'b11, 0,  32'hDEAD,     7, 32'h1234,     0, 2'b11, 1, 10, 32'hA0,       2, 32'hC00};
    vt[12] = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b01, 1, 10, 32'hA0,       3, 32'hC80};
    vt[13] = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b11, 1, 11, 32'hB0,       2, 32'h880};
    vt[14] = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b11, 1, 7,  32'h1234,     1, 32'h80};
    vt[15] = '{2'b00, 0,  32'h0,        0, 32'h0,        1, 2'b11, 0, 0,  32'h0,        0, 32'h0};

    rstn = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'b11, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table: outputs reflect state before the upcoming edge; inputs act at it.
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].v, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1, vt[i].rdy);
      check_all($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_vld, vt[i].e_addr,
                vt[i].e_data, vt[i].e_fill, vt[i].e_mask);
      @(posedge clk);
      #1;
    end

    // Reset mid-stream with three entries buffered.
    drive(2'b11, 12, 32'hC0, 13, 32'hD0, 1'b0);
    @(posedge clk);
    #1;
    drive(2'b01, 14, 32'hE0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 0, 0, 1'b0);
    check_all("prereset", 2'b01, 1'b1, 5'd12, 32'hC0, 3'd3, 32'h7000);
    #2 rstn = 1'b0;
    #1;
    check_all("midreset", 2'b11, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus.async_rd_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("postreset%0d valid", c), 64'(bus.async_rd_valid), 64'd0);
      check($sformatf("postreset%0d fill", c), 64'(bus.fill_level), 64'd0);
    end

    // Random push/pop across the wrap point with frequent x9 duplicates.
    q.delete();
    for (int c = 0; c < 10; c++) begin
      case ($urandom_range(0, 2))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      for (int l = 0; l < 2; l++) begin
        a[l] = ($urandom_range(0, 2) != 0) ? 5'd9 : 5'($urandom_range(0, 31));
        d[l] = $urandom;
      end
      rdy = 1'($urandom_range(0, 1));
      drive(v, a[0], d[0], a[1], d[1], rdy);
      check_model($sformatf("rand%0d", c));
      step_model(v, a[0], d[0], a[1], d[1], rdy);
    end
    for (int c = 0; c < DEPTH + 1; c++) begin
      drive(2'b00, 0, 0, 0, 0, 1'b1);
      check_model($sformatf("drain%0d", c));
      step_model(2'b00, 0, 0, 0, 0, 1'b1);
    end
    check_model("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/rvv_xrf_wb_collector.md
Name: rvv_xrf_wb_collector

Overview:
- Receiving end of the vector backend's scalar-regfile retire interface (rt_xrf valid/data/ready, NUM_RT_UOP lanes).
- Accepts up to N_IN in-order retire writes per cycle and buffers them in a circular FIFO.
- Drains one write per cycle onto the single async_rd valid/ready writeback port of the scalar core.
- Exports a pending-write mask so the scalar core can stall reads of registers with outstanding vector writebacks.

Parameters:
- N_IN, 2, number of retire lanes (matches NUM_RT_UOP).
- DEPTH, 4, FIFO entries; constraint DEPTH >= N_IN.
- ADDR_W, 5, scalar register index width.
- DATA_W, 32, scalar register data width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  N_IN  per-lane retire write request; lane 0 oldest
- in_addr  in  N_IN*ADDR_W  per-lane destination register index (rt_index)
- in_data  in  N_IN*DATA_W  per-lane write data (rt_data)
- in_ready  out  N_IN  per-lane accept
- async_rd_valid  out  1  writeback request to scalar regfile
- async_rd_addr  out  ADDR_W  writeback register index
- async_rd_data  out  DATA_W  writeback data
- async_rd_ready  in  1  scalar regfile accepts writeback
- pending_mask  out  2**ADDR_W  bit r set while a write to xr is buffered or presented
- fill_level  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- Design decision: one clock domain, clk; rstn is asynchronous, active-low.
- Reset values:
  - count, read pointer and write pointer = 0.
  - async_rd_valid = 0; pending_mask = 0; fill_level = 0.
  - in_ready = all ones, since DEPTH >= N_IN.
  - async_rd_addr/data are don't-care while valid = 0; the bench checks them as 0 at reset.
- Reset mid-operation discards all buffered entries. No writeback is emitted after rstn deasserts until new input arrives.
- in_ready[i] = (DEPTH - count) > i.
  - Computed from registered count only.
  - No combinational path from in_valid or async_rd_ready to in_ready.
  - A pop in the same cycle does not free space until the next cycle.
- Input ordering:
  - in_valid must be contiguous from lane 0. A gap is a protocol violation and is flagged by an assertion.
  - Lane i is accepted when in_valid[i] & in_ready[i].
  - Accepted lanes enqueue in lane order: lane 0 goes to wptr, lane 1 to wptr+1, and so on.
- x0 filter: accepted lanes with in_addr == 0 are handshaken but not enqueued. Remaining lanes compact, keeping their relative order.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- Output:
  - async_rd_valid = (count != 0); async_rd_addr/data = entry[rptr].
  - Driven directly from storage, with no combinational path from the inputs.
  - Latency: a write accepted at edge T appears on the output no earlier than cycle T+1.
  - Once valid is asserted, addr/data stay stable until async_rd_ready is sampled high.
- Pop: async_rd_valid & async_rd_ready advances rptr by 1.
- Simultaneous push and pop: count_next = count + pushes - pop. This never overflows, because pushes <= DEPTH - count.
- Full (count == DEPTH): in_ready = 0 on all lanes; output continues to drain.
- Empty: async_rd_valid = 0. Pushes in that cycle do not bypass to the output.
- pending_mask:
  - Combinational OR of one-hot(addr) over all valid entries.
  - Bit 0 is always 0.
  - A bit clears on the cycle after the last entry for that register pops.
  - Duplicate addresses are allowed; each entry drains separately, in order.
- fill_level = count.

Test Plan:
- Reset check: rstn low mid-stream with 3 entries buffered -> async_rd_valid=0, pending_mask=0, fill_level=0, in_ready=2'b11; after release, no spurious writeback.
- Dual-lane push with ready held high: lane0 (x5, 0xAAAA0001) and lane1 (x6, 0xBBBB0002) in one cycle -> x5 on cycle T+1, x6 on T+2; pending_mask bits 5 and 6 set at T+1; bit 5 clears at T+2, bit 6 at T+3.
- Back-pressure: async_rd_ready=0, push 4 writes -> fill_level=4, in_ready=2'b00, output stable at the first entry; raise ready for 1 cycle -> exactly one pop; in_ready=2'b01 the following cycle.
- Partial accept: count=3, both lanes valid -> only lane 0 accepted (in_ready=2'b01); lane 1 re-presented later drains after lane 0.
- x0 filter: lane0 x0 and lane1 x7 (0x1234) -> both handshaken; fill_level +1; only x7 is written back; pending_mask bit 0 never set.
- Wrap and duplicates: 10 random cycles of push/pop across the DEPTH boundary with repeated x9 writes -> output sequence equals input order; pending_mask[9] stays high until the last x9 entry pops.
